// File: rtl/fetch_pc_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit_if
// Bundle between the fetch PC unit and its neighbours. The unit drives the
// instruction-memory word address and the producer side of the IF/ID register.
// It receives stall and redirect requests from later stages.
// Optional macro FETCH_MISALIGN_CHECK_EN adds the sticky misalign flag.
// -----------------------------------------------------------------------------
interface fetch_pc_unit_if #(
   parameter int unsigned ADDR_SIZE = 10
);

   // requests from hazard unit / branch resolution
   logic                   stall;
   logic                   redirect;
   logic [ADDR_SIZE+1:0]   redirect_pc;

   // outputs of the fetch unit
   logic [ADDR_SIZE-1:0]   imem_addr;
   logic [ADDR_SIZE+1:0]   pc_if;
   logic                   inst_valid_if;
   logic                   if_id_enable;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic                   misalign;
`endif

   // fetch unit side
   modport master (
      input  stall, redirect, redirect_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
      output misalign,
`endif
      output imem_addr, pc_if, inst_valid_if, if_id_enable
   );

   // pipeline / hazard side
   modport slave (
      output stall, redirect, redirect_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
      input  misalign,
`endif
      input  imem_addr, pc_if, inst_valid_if, if_id_enable
   );

endinterface : fetch_pc_unit_if

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// Instruction-fetch front end. Holds the architectural fetch PC, drives the
// word address of a synchronous (1-cycle latency) instruction memory, and
// applies stall / redirect requests. pc_if is the byte PC of the word that
// memory returns this cycle; inst_valid_if marks that word as real or bubble.
//
// Two-state FSM: BOOT (one cycle after reset, presents RESET_PC, emits a
// bubble) then RUN until the next reset.
//
// Optional macro FETCH_MISALIGN_CHECK_EN: adds a sticky flag that records any
// redirect accepted in RUN whose target has nonzero low bits. Without it, the
// low two bits of redirect_pc are simply dropped.
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
   parameter int unsigned          ADDR_SIZE = 10,
   parameter logic [ADDR_SIZE+1:0] RESET_PC  = '0
) (
   input  logic              clk,
   input  logic              rst,
   fetch_pc_unit_if.master   bus
);

   localparam int unsigned PC_W = ADDR_SIZE + 2;

   // Fetch always works on whole words; a misaligned RESET_PC is treated as
   // the word that contains it.
   localparam logic [PC_W-1:0] RESET_PC_WORD = {RESET_PC[PC_W-1:2], 2'b00};

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state;
   logic [PC_W-1:0]   pc_if;
   logic [PC_W-1:0]   next_pc;
   logic [PC_W-1:0]   redirect_target;
   logic              inst_valid;
   logic              id_enable;

   // Redirect target with the byte-offset bits cleared.
   assign redirect_target = {bus.redirect_pc[PC_W-1:2], 2'b00};

   // Next-PC selection and the IF/ID control outputs, prioritised BOOT >
   // redirect > stall > sequential.
   always_comb begin
      // NOTE: every output gets a default before the priority chain, so no
      // path leaves a value unassigned and no latch is inferred.
      next_pc    = pc_if + PC_W'(4);
      inst_valid = 1'b1;
      id_enable  = 1'b1;
      if (state == BOOT) begin
         next_pc    = RESET_PC_WORD;
         inst_valid = 1'b0;
      end else if (bus.redirect) begin
         // Word in IF is wrong-path: squash it but still load the bubble.
         next_pc    = redirect_target;
         inst_valid = 1'b0;
      end else if (bus.stall) begin
         // Re-present the same word so memory output stays stable.
         next_pc    = pc_if;
         id_enable  = 1'b0;
      end
   end

   // FSM state and registered fetch PC; the PC wraps naturally at 2^PC_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BOOT;
         pc_if <= RESET_PC_WORD;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed above, independent of statement order.
         pc_if <= next_pc;
         case (state)
            BOOT:    state <= RUN;
            RUN:     state <= RUN;
            default: state <= BOOT;
         endcase
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   logic misalign_q;

   // Sticky flag: set by a misaligned redirect accepted in RUN, cleared only
   // by reset. Redirects seen during BOOT are ignored, so they cannot set it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_q <= 1'b0;
      end else if (state == RUN && bus.redirect &&
                   bus.redirect_pc[1:0] != 2'b00) begin
         misalign_q <= 1'b1;
      end
   end

   assign bus.misalign = misalign_q;
`else
   // Byte-offset bits of the target are intentionally discarded.
   logic unused_redirect_low;
   assign unused_redirect_low = ^bus.redirect_pc[1:0];
`endif

   assign bus.imem_addr     = next_pc[PC_W-1:2];
   assign bus.pc_if         = pc_if;
   assign bus.inst_valid_if = inst_valid;
   assign bus.if_id_enable  = id_enable;

endmodule : fetch_pc_unit

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
// Scoreboard bench: the driver applies one directed vector per cycle just
// after the rising edge and queues the hand-computed expected outputs; a
// monitor samples the DUT on the falling edge and compares against the queue.
// A 10-bit-address instance covers the main behaviour; a 2-bit-address
// instance covers PC wrap in a tiny address space.
// Build with +define+FETCH_MISALIGN_CHECK_EN to also check the misalign flag.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic rst_s = 1'b1;

   always #5 clk = ~clk;

   fetch_pc_unit_if #(.ADDR_SIZE(10)) m_bus ();
   fetch_pc_unit_if #(.ADDR_SIZE(2))  s_bus ();

   fetch_pc_unit #(.ADDR_SIZE(10), .RESET_PC(12'h000)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (m_bus)
   );

   fetch_pc_unit #(.ADDR_SIZE(2), .RESET_PC(4'h0)) u_dut_small (
      .clk (clk),
      .rst (rst_s),
      .bus (s_bus)
   );

   typedef struct {
      bit          sel;     // 0 = main instance, 1 = small instance
      int          id;
      logic [11:0] pc;
      logic [9:0]  addr;
      logic        valid;
      logic        en;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_id = 0;

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Apply one cycle of stimulus and queue what the DUT must show in it.
   task automatic step(input bit sel, input logic r, input logic s, input logic rd,
                       input logic [11:0] rpc, input logic [11:0] e_pc,
                       input logic [9:0] e_addr, input logic e_v, input logic e_en,
                       input logic e_mis);
      exp_t e;
      @(posedge clk);
      #1;
      if (!sel) begin
         rst               = r;
         m_bus.stall       = s;
         m_bus.redirect    = rd;
         m_bus.redirect_pc = rpc;
      end else begin
         rst_s             = r;
         s_bus.stall       = s;
         s_bus.redirect    = rd;
         s_bus.redirect_pc = rpc[3:0];
      end
      e.sel   = sel;
      e.id    = vec_id;
      e.pc    = e_pc;
      e.addr  = e_addr;
      e.valid = e_v;
      e.en    = e_en;
      e.mis   = e_mis;
      exp_q.push_back(e);
      vec_id++;
   endtask

   // Monitor: compare on the falling edge whenever a vector is pending.
   initial begin
      exp_t        e;
      logic [11:0] a_pc;
      logic [9:0]  a_addr;
      logic        a_v, a_en, a_mis;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!e.sel) begin
               a_pc   = m_bus.pc_if;
               a_addr = m_bus.imem_addr;
               a_v    = m_bus.inst_valid_if;
               a_en   = m_bus.if_id_enable;
`ifdef FETCH_MISALIGN_CHECK_EN
               a_mis  = m_bus.misalign;
`else
               a_mis  = 1'b0;
`endif
            end else begin
               a_pc   = 12'(s_bus.pc_if);
               a_addr = 10'(s_bus.imem_addr);
               a_v    = s_bus.inst_valid_if;
               a_en   = s_bus.if_id_enable;
`ifdef FETCH_MISALIGN_CHECK_EN
               a_mis  = s_bus.misalign;
`else
               a_mis  = 1'b0;
`endif
            end
            check($sformatf("v%0d pc_if", e.id),         a_pc,          e.pc);
            check($sformatf("v%0d imem_addr", e.id),     12'(a_addr),   12'(e.addr));
            check($sformatf("v%0d inst_valid_if", e.id), 12'(a_v),      12'(e.valid));
            check($sformatf("v%0d if_id_enable", e.id),  12'(a_en),     12'(e.en));
`ifdef FETCH_MISALIGN_CHECK_EN
            check($sformatf("v%0d misalign", e.id),      12'(a_mis),    12'(e.mis));
`endif
         end
      end
   end

   // Hard bound on run time.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      m_bus.stall = 1'b0; m_bus.redirect = 1'b0; m_bus.redirect_pc = '0;
      s_bus.stall = 1'b0; s_bus.redirect = 1'b0; s_bus.redirect_pc = '0;
      repeat (3) @(posedge clk);

      // ---- main instance: boot and sequential fetch -------------------------
      //      sel rst stl red rpc      pc       addr    v  en mis
      step(0, 0, 0, 0, 12'h000, 12'h000, 10'h000, 0, 1, 0);  // BOOT bubble
      step(0, 0, 0, 0, 12'h000, 12'h000, 10'h001, 1, 1, 0);
      step(0, 0, 0, 0, 12'h000, 12'h004, 10'h002, 1, 1, 0);
      step(0, 0, 0, 0, 12'h000, 12'h008, 10'h003, 1, 1, 0);
      step(0, 0, 0, 0, 12'h000, 12'h00C, 10'h004, 1, 1, 0);
      // stall three cycles at 0x10
      step(0, 0, 1, 0, 12'h000, 12'h010, 10'h004, 1, 0, 0);
      step(0, 0, 1, 0, 12'h000, 12'h010, 10'h004, 1, 0, 0);
      step(0, 0, 1, 0, 12'h000, 12'h010, 10'h004, 1, 0, 0);
      step(0, 0, 0, 0, 12'h000, 12'h010, 10'h005, 1, 1, 0);
      step(0, 0, 0, 0, 12'h000, 12'h014, 10'h006, 1, 1, 0);
      step(0, 0, 0, 0, 12'h000, 12'h018, 10'h007, 1, 1, 0);
      step(0, 0, 0, 0, 12'h000, 12'h01C, 10'h008, 1, 1, 0);
      // redirect to 0x40 at pc 0x20
      step(0, 0, 0, 1, 12'h040, 12'h020, 10'h010, 0, 1, 0);
      step(0, 0, 0, 0, 12'h000, 12'h040, 10'h011, 1, 1, 0);
      // redirect + stall together: redirect wins
      step(0, 0, 1, 1, 12'h080, 12'h044, 10'h020, 0, 1, 0);
      step(0, 0, 0, 0, 12'h000, 12'h080, 10'h021, 1, 1, 0);
      // back-to-back redirects
      step(0, 0, 0, 1, 12'h100, 12'h084, 10'h040, 0, 1, 0);
      step(0, 0, 0, 1, 12'h200, 12'h100, 10'h080, 0, 1, 0);
      step(0, 0, 0, 0, 12'h000, 12'h200, 10'h081, 1, 1, 0);
      // misaligned redirect target 0x42 -> fetch 0x40
      step(0, 0, 0, 1, 12'h042, 12'h204, 10'h010, 0, 1, 0);
      step(0, 0, 0, 0, 12'h000, 12'h040, 10'h011, 1, 1, 1);
      for (int i = 0; i < 10; i++)
         step(0, 0, 0, 0, 12'h000, 12'(12'h044 + 4 * i), 10'(10'h012 + i), 1, 1, 1);
      // wrap at the top of the 12-bit PC space
      step(0, 0, 0, 1, 12'hFFC, 12'h06C, 10'h3FF, 0, 1, 1);
      step(0, 0, 0, 0, 12'h000, 12'hFFC, 10'h000, 1, 1, 1);
      step(0, 0, 0, 0, 12'h000, 12'h000, 10'h001, 1, 1, 1);
      // async reset mid-run with a redirect in flight (pc_if was 0x004)
      step(0, 1, 1, 1, 12'h300, 12'h000, 10'h000, 0, 1, 0);
      // leave reset with stall+redirect held: BOOT ignores both
      step(0, 0, 1, 1, 12'h300, 12'h000, 10'h000, 0, 1, 0);
      step(0, 0, 0, 0, 12'h000, 12'h000, 10'h001, 1, 1, 0);
      step(0, 0, 0, 0, 12'h000, 12'h004, 10'h002, 1, 1, 0);

      // ---- small instance (ADDR_SIZE=2): wrap and async reset --------------
      step(1, 0, 0, 0, 12'h000, 12'h000, 10'h000, 0, 1, 0);
      step(1, 0, 0, 0, 12'h000, 12'h000, 10'h001, 1, 1, 0);
      step(1, 0, 0, 0, 12'h000, 12'h004, 10'h002, 1, 1, 0);
      step(1, 0, 0, 0, 12'h000, 12'h008, 10'h003, 1, 1, 0);
      step(1, 0, 0, 0, 12'h000, 12'h00C, 10'h000, 1, 1, 0);
      step(1, 0, 0, 0, 12'h000, 12'h000, 10'h001, 1, 1, 0);
      step(1, 0, 0, 0, 12'h000, 12'h004, 10'h002, 1, 1, 0);
      step(1, 1, 0, 0, 12'h000, 12'h000, 10'h000, 0, 1, 0);  // pc_if was 0x8

      // drain: bounded wait for the monitor to consume every vector
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      check("scoreboard_drain", 12'(exp_q.size()), 12'h000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fetch_pc_unit

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end that produces the producer-side inputs of the IF/ID pipeline register. Keeps the architectural fetch PC and drives the word address of the synchronous instruction memory, which has one cycle of read latency. Applies stall and branch/jump redirect requests from later stages. Reports, alongside each PC, whether the instruction currently returned by memory is valid or a bubble.

## Interface
Parameters:
- ADDR_SIZE, 10, instruction-memory word-address width; byte PC width is ADDR_SIZE+2
- RESET_PC, 0, byte PC fetched first after reset; must be 4-byte aligned

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hazard unit requests that fetch hold
- redirect  in  1  taken branch/jump resolved downstream; pulse, one cycle per event
- redirect_pc  in  ADDR_SIZE+2  byte target PC for redirect
- imem_addr  out  ADDR_SIZE  word address to imem; combinational next-PC
- pc_if  out  ADDR_SIZE+2  byte PC of the instruction imem returns this cycle; registered
- inst_valid_if  out  1  0 = imem data this cycle is a bubble
- if_id_enable  out  1  drives the IF/ID register enable
- misalign  out  1  sticky misaligned-redirect flag; present only with FETCH_MISALIGN_CHECK_EN

Reset is asynchronous and active-high. The single clock is clk.

## Operation
- State machine with two states, BOOT and RUN. Reset forces BOOT. BOOT always moves to RUN on the next edge. RUN holds until reset.
- next_pc priority:
  - BOOT: RESET_PC
  - redirect: {redirect_pc[ADDR_SIZE+1:2], 2'b00}
  - stall: pc_if
  - otherwise: pc_if + 4
- imem_addr = next_pc[ADDR_SIZE+1:2], combinational.
- pc_if <= next_pc on every rising edge.
- The increment wraps modulo 2^(ADDR_SIZE+2): the maximum PC is followed by 0. No overflow flag is raised.
- BOOT:
  - stall and redirect are ignored
  - inst_valid_if = 0
  - if_id_enable = 1, so a bubble enters ID
- RUN, no stall, no redirect: inst_valid_if = 1, if_id_enable = 1.
- RUN, stall only:
  - if_id_enable = 0 and inst_valid_if = 1
  - the same word is re-presented, so imem output stays stable
- RUN, redirect (with or without stall):
  - redirect wins over stall
  - the instruction in IF is wrong-path, so inst_valid_if = 0 in the same cycle
  - if_id_enable = 1, so the bubble is loaded into ID
  - the target instruction arrives on the next cycle with inst_valid_if = 1
- Back-to-back redirects: each one is honoured, and the latest target wins.

## Timing
- Reset values: pc_if = RESET_PC, state = BOOT, inst_valid_if = 0, if_id_enable = 1, misalign = 0, imem_addr = RESET_PC word.
- Fetch latency: an address driven in cycle N returns data in cycle N+1, where pc_if equals that address.
- Redirect penalty seen by fetch: 1 bubble.
- Throughput: one instruction per cycle when not stalled.
- Reset asserted mid-operation: outputs take their reset values immediately (asynchronously). An in-flight redirect is discarded.
- inst_valid_if and if_id_enable are combinational from state, stall and redirect. imem_addr is combinational from state, stall, redirect, redirect_pc and pc_if.

## Configuration
FETCH_MISALIGN_CHECK_EN
- Defined:
  - misalign port exists
  - misalign sets when redirect is accepted in RUN with redirect_pc[1:0] != 0, and stays set until rst
  - the redirect is still taken, with the low bits forced to 00
- Undefined:
  - no misalign port and no flag register
  - redirect_pc[1:0] is silently ignored

## Test plan
- Reset release, no stall or redirect, RESET_PC=0 → cycle 0 BOOT with valid=0 and imem_addr=0; cycles 1-4 pc_if = 0, 4, 8, 12 with valid=1.
- Stall for 3 cycles at pc_if=0x10 → pc_if holds 0x10, imem_addr holds 4, if_id_enable=0; after release, pc_if = 0x14.
- Redirect to 0x40 while pc_if=0x20 → that cycle valid=0 and imem_addr=0x10; next cycle pc_if=0x40 with valid=1.
- Redirect to 0x80 and stall in the same cycle → redirect wins, if_id_enable=1, next pc_if=0x80; also redirect and stall asserted during BOOT are ignored.
- ADDR_SIZE=2, run through pc_if=0xC → next pc_if=0x0; then assert rst mid-run → pc_if=RESET_PC immediately and state=BOOT.
- With the macro, redirect_pc=0x42 → pc_if=0x40 and misalign=1, still set 10 cycles later; without the macro, the same stimulus gives pc_if=0x40 and no flag.
